// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between two requesters.
//            Port 0 is the CPU load/store path, port 1 the loader/debug path.
//            One transaction at a time: a one-cycle memory command, an
//            optional MEM_LAT-cycle wait for read data, then a one-cycle ack
//            to the winning requester with the captured read data.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            req0/we0/addr0/wdata0         - port 0 request (held until ack0)
//            ack0/rdata0                   - port 0 completion pulse / read data
//            req1/we1/addr1/wdata1         - port 1 request (held until ack1)
//            ack1/rdata1                   - port 1 completion pulse / read data
//            mem_en/mem_we/mem_addr/mem_wdata - memory command (qualify by mem_en)
//            mem_rdata                     - memory read data, MEM_LAT after mem_en
//            gnt                           - one-hot current owner, 0 when idle
//            busy                          - transaction in progress
// Options  : DMEM_ARB_RR_EN - when defined, simultaneous requests are resolved
//            round-robin; otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    gnt,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   // Counter wide enough to hold MEM_LAT
   localparam int c_cw = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [c_cw-1:0] c_lat = c_cw'(MEM_LAT);
   localparam logic [c_cw-1:0] c_one = c_cw'(1);

   state_t          r_state;
   state_t          w_next;
   logic            r_owner;       // index of the port being served
   logic            r_last_grant;  // index of the most recent winner
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [c_cw-1:0] r_cnt;
   logic [DW-1:0]   r_rdata0;
   logic [DW-1:0]   r_rdata1;

   logic            w_any_req;
   logic            w_tie_winner;
   logic            w_winner;

   assign w_any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
   // On a tie, the port that did not win last time goes next
   assign w_tie_winner = ~r_last_grant;
`else
   // Fixed priority: port 0 always wins a tie; last_grant is tracked but
   // has no influence on the decision in this build
   assign w_tie_winner = r_last_grant & 1'b0;
`endif

   // A lone request wins regardless of history
   assign w_winner = (req0 && req1) ? w_tie_winner : req1;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_ISSUE;
         S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
         // cnt==1 marks the cycle in which mem_rdata is valid
         S_WAIT:  if (r_cnt == c_one) w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch, wait counter and read-data capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         if (r_state == S_IDLE && w_any_req) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_we         <= w_winner ? we1    : we0;
            r_addr       <= w_winner ? addr1  : addr0;
            r_wdata      <= w_winner ? wdata1 : wdata0;
         end

         if (r_state == S_ISSUE) begin
            r_cnt <= c_lat;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - c_one;
            if (r_cnt == c_one) begin
               if (r_owner) begin
                  r_rdata1 <= mem_rdata;
               end else begin
                  r_rdata0 <= mem_rdata;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs (decoded from state; memory fields hold their last value)
   // ------------------------------------------------------------------
   assign mem_en    = (r_state == S_ISSUE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   assign busy   = (r_state != S_IDLE);
   assign gnt    = busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign ack0   = (r_state == S_ACK) && !r_owner;
   assign ack1   = (r_state == S_ACK) &&  r_owner;
   assign rdata0 = r_rdata0;
   assign rdata1 = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with MEM_LAT=2.
//            A small memory model returns read data exactly LAT cycles after
//            the mem_en cycle and a poison value otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic        ack0, ack1, mem_en, mem_we, busy;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  gnt;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .gnt(gnt), .busy(busy)
   );

   // Memory model: word-addressed, read data delayed by LAT cycles
   logic [31:0] mem  [0:63];
   logic [31:0] pipe [0:LAT-1];
   logic        mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         mem[0]    <= 32'h0000_0011;
         mem[1]    <= 32'h0000_0022;
         mem[8]    <= 32'hC0FF_EE00;
         mem_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
      pipe[0] <= mem_en ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[LAT-1];

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_rd0 = '0;
   logic [31:0] exp_rd1 = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input int port, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (port == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"},  gnt,    2'b00);
      check({tag, "_busy"}, busy,   1'b0);
      check({tag, "_en"},   mem_en, 1'b0);
      check({tag, "_ack0"}, ack0,   1'b0);
      check({tag, "_ack1"}, ack1,   1'b0);
   endtask

   task automatic wait_issue(output bit ok);
      int n = 0;
      while (!mem_en && n < 8) begin tick(); n++; end
      ok = mem_en;
   endtask

   task automatic wait_ack(output bit ok);
      int n = 0;
      while (!(ack0 || ack1) && n < 8) begin tick(); n++; end
      ok = ack0 || ack1;
   endtask

   // One complete transaction on a single port with cycle-exact checks.
   // exp_dly: cycles from raising req until the ISSUE cycle.
   task automatic do_txn(input int port, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input int exp_dly, output int ack_cyc);
      int   n;
      int   lat;
      logic ak;
      drive(port, 1'b1, w, a, d);
      n = 0;
      do begin tick(); n++; end while (!mem_en && n < 8);
      check("issue_dly",  n,        exp_dly);
      check("issue_gnt",  gnt,      (port == 0) ? 2'b01 : 2'b10);
      check("issue_busy", busy,     1'b1);
      check("issue_we",   mem_we,   w);
      check("issue_addr", mem_addr, a);
      if (w) check("issue_wdata", mem_wdata, d);
      lat = w ? 1 : 1 + LAT;
      for (int i = 1; i <= lat; i++) begin
         tick();
         ak = (port == 0) ? ack0 : ack1;
         check("ack_timing", ak,     (i == lat));
         check("en_after",   mem_en, 1'b0);
      end
      check("other_ack", (port == 0) ? ack1 : ack0, 1'b0);
      if (!w) begin
         if (port == 0) exp_rd0 = rd;
         else           exp_rd1 = rd;
      end
      check("rdata0", rdata0, exp_rd0);
      check("rdata1", rdata1, exp_rd1);
      drive(port, 1'b0, w, a, d);
      ack_cyc = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  a1, a2;
      int  exp_p, last_p;
      bit  ok;

      // ---------------- reset with both requests pending ----------------
      drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
      drive(1, 1'b1, 1'b1, 32'h24, 32'h5A5A_5A5A);
      rst = 1'b1;
      tick();
      tick();
      check("rst_ack0",   ack0,      1'b0);
      check("rst_ack1",   ack1,      1'b0);
      check("rst_rdata0", rdata0,    32'h0);
      check("rst_rdata1", rdata1,    32'h0);
      check("rst_en",     mem_en,    1'b0);
      check("rst_we",     mem_we,    1'b0);
      check("rst_addr",   mem_addr,  32'h0);
      check("rst_wdata",  mem_wdata, 32'h0);
      check("rst_gnt",    gnt,       2'b00);
      check("rst_busy",   busy,      1'b0);
      rst = 1'b0;

      // ---------------- tie after reset: port 0 first ----------------
      tick();                                   // cycle 1: ISSUE port 0
      check("tie_gnt0",  gnt,      2'b01);
      check("tie_en0",   mem_en,   1'b1);
      check("tie_addr0", mem_addr, 32'h20);
      check("tie_we0",   mem_we,   1'b0);
      tick();
      check("tie_wait_a", ack0, 1'b0);
      tick();
      check("tie_wait_b", ack0, 1'b0);
      tick();                                   // cycle 4: ACK port 0
      check("tie_ack0",   ack0,   1'b1);
      check("tie_rdata0", rdata0, 32'hC0FF_EE00);
      exp_rd0 = 32'hC0FF_EE00;
      drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
      tick();                                   // cycle 5: IDLE
      check("tie_idle_gnt", gnt,  2'b00);
      check("tie_idle_bsy", busy, 1'b0);
      tick();                                   // cycle 6: ISSUE port 1
      check("tie_gnt1",   gnt,       2'b10);
      check("tie_addr1",  mem_addr,  32'h24);
      check("tie_we1",    mem_we,    1'b1);
      check("tie_wdata1", mem_wdata, 32'h5A5A_5A5A);
      tick();                                   // cycle 7: ACK port 1
      check("tie_ack1",   ack1,   1'b1);
      check("tie_rdata1", rdata1, 32'h0);
      drive(1, 1'b0, 1'b1, 32'h24, 32'h5A5A_5A5A);
      tick();
      check_idle("tie_end");

      // ---------------- write then read back on port 0 ----------------
      do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1, a1);
      do_txn(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, a2);
      tick();
      check_idle("wr_rd_end");

      // ---------------- reset in the middle of a read ----------------
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();                                   // ISSUE
      check("mid_en", mem_en, 1'b1);
      tick();                                   // WAIT 1
      tick();                                   // WAIT 2 (data arriving)
      check("mid_noack", ack0, 1'b0);
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
      tick();
      rst = 1'b0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      check_idle("mid_rst");
      check("mid_rdata0", rdata0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_late_ack0",   ack0,   1'b0);
         check("mid_late_rdata0", rdata0, 32'h0);
      end

      // ---------------- persistent contention ----------------
      drive(0, 1'b1, 1'b1, 32'h40, 32'hA0A0_A0A0);
      drive(1, 1'b1, 1'b1, 32'h44, 32'hB1B1_B1B1);
      last_p = 0;
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         exp_p = k % 2;
`else
         exp_p = 0;
`endif
         wait_issue(ok);
         check("arb_issue_to", ok, 1'b1);
         check("arb_gnt",  gnt,      (exp_p == 1) ? 2'b10 : 2'b01);
         check("arb_addr", mem_addr, (exp_p == 1) ? 32'h44 : 32'h40);
         wait_ack(ok);
         check("arb_ack_to",   ok,   1'b1);
         check("arb_ack_port", ack1, exp_p[0]);
         last_p = exp_p;
      end
      // drop the port just served, then let the other one finish
      drive(last_p, 1'b0, 1'b1, (last_p == 1) ? 32'h44 : 32'h40, 32'h0);
      wait_issue(ok);
      check("drain_issue_to", ok, 1'b1);
      check("drain_gnt", gnt, (last_p == 1) ? 2'b01 : 2'b10);
      wait_ack(ok);
      check("drain_ack_to", ok, 1'b1);
      check("drain_ack1",   ack1, (last_p == 0));
      drive(1 - last_p, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      check_idle("drain_end");

      // ---------------- back-to-back port 1 reads ----------------
      do_txn(1, 1'b0, 32'h0, 32'h0, 32'h11, 1, a1);
      do_txn(1, 1'b0, 32'h4, 32'h0, 32'h22, 2, a2);
      check("b2b_gap", a2 - a1, 3 + LAT);
      tick();
      check_idle("b2b_end");
      check("b2b_rdata0", rdata0, 32'h0);
      check("b2b_rdata1", rdata1, 32'h22);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path, port 1 is the loader/debug path.
- Serialises transactions, drives the memory command for exactly one cycle per transaction, and waits MEM_LAT cycles for read data.
- Returns a one-cycle ack with captured read data to the requester.
- Sits between the CPU core and the data memory; the CPU stalls on req0 && !ack0.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles (>=1): mem_rdata is valid MEM_LAT cycles after the mem_en cycle

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write enable
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 completion pulse (1 cycle)
rdata0  out  DW  port 0 read data, valid with ack0, held after
req1/we1/addr1/wdata1  in  1/1/AW/DW  port 1 request, same rules as port 0
ack1/rdata1  out  1/DW  port 1 completion, same rules as port 0
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable (qualified by mem_en)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
gnt  out  2  one-hot owner; nonzero from ISSUE through ACK
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, at any state): state=IDLE; all outputs 0 (ack*, rdata*, mem_*, gnt, busy); last_grant=1; wait counter=0.
- Requester rule: req/we/addr/wdata held stable from assertion until the cycle ack is high. Requester may drop or re-raise req after the ack edge.
- IDLE:
  - No req: stay.
  - Any req high at edge: select winner, latch its we/addr/wdata, set gnt, go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1, mem_we/mem_addr/mem_wdata = latched values.
  - Write -> ACK.
  - Read -> WAIT with counter=MEM_LAT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - On the cycle counter==1 (MEM_LAT cycles after ISSUE), capture mem_rdata into the winner's rdata register, then go to ACK.
- ACK (1 cycle): ack of winner=1 -> IDLE. gnt clears entering IDLE. Requests are not sampled in ACK.
- Latency, with req sampled at edge E0 (IDLE):
  - ISSUE in cycle 1.
  - Write ack in cycle 2.
  - Read ack in cycle 2+MEM_LAT.
  - Next transaction earliest ISSUE in cycle 4 (write) or 4+MEM_LAT (read).
- rdataN updates only on a read ack to port N. Write acks and the other port's transactions leave it unchanged.
- mem_addr/mem_wdata/mem_we outside ISSUE: hold the last latched values. Consumers qualify them with mem_en.
- Default arbitration is fixed priority: port 0 wins on simultaneous req. Port 1 can starve if req0 is re-raised every IDLE.
- last_grant updates to the winner index on each IDLE->ISSUE transition.
- Reset mid-transaction: in-flight transaction abandoned, no ack issued, late mem_rdata ignored. Requester must re-request after reset.
- Only one outstanding memory transaction at any time.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin. On simultaneous req, the port != last_grant wins. A single req is granted regardless of last_grant. After reset (last_grant=1) port 0 wins the first tie.
- Undefined: fixed priority as above; last_grant still maintained but unused.

Test Plan:
- Reset: assert rst for 2 cycles with req0=req1=1 -> all outputs 0, busy=0. First grant after release goes to port 0.
- Write then read, MEM_LAT=2:
  - Port 0 write addr 0x10 data 0xDEADBEEF -> mem_en=1 with mem_we=1 only in cycle 1; ack0 in cycle 2; rdata0 stays 0.
  - Then read addr 0x10 -> ack0 exactly 4 cycles after ISSUE-sample edge; rdata0=0xDEADBEEF.
- Tie, fixed priority: req0 (read 0x20) and req1 (write 0x24, 0x5A5A5A5A) raised same cycle -> gnt=01, then ack0. Next IDLE gives gnt=10, then ack1. mem_addr sequence is 0x20 then 0x24.
- Starvation vs RR: both reqs re-raised immediately after each ack for 4 transactions.
  - Without DMEM_ARB_RR_EN: all 4 grants to port 0.
  - With it: grants 0,1,0,1.
- Reset mid-read: MEM_LAT=3, rst asserted in second WAIT cycle -> next cycle state IDLE, gnt=0, busy=0. No ack0 pulse and rdata0=0 even when mem_rdata arrives.
- Back-to-back port 1 reads, MEM_LAT=1, addrs 0x0 and 0x4 with memory returning 0x11 and 0x22 -> ack1 pulses 4 cycles apart; rdata1=0x11 then 0x22; rdata0 unchanged.
